// File: rtl/seg_scan_monitor.sv
// Seven-segment scan monitor: watches a multiplexed anode/cathode display bus,
// waits for each digit to settle, decodes the segment pattern back to a hex
// value and reports per-digit status, frame completion and scan errors.
module seg_scan_monitor #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  anode,
    input  logic [6:0]  cathode,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  digit_blank,
    output logic        frame_done,
    output logic        err_multi,
    output logic        err_pattern,
    output logic        scan_timeout
);

    localparam logic [7:0]  SETTLE_TERM = 8'(SETTLE_CYCLES);
    localparam logic [19:0] TMO_TERM    = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  anode_s_reg, anode_p_reg;
    logic [6:0]  cathode_s_reg, cathode_p_reg;
    logic [7:0]  seen_reg;
    logic [19:0] tmo_cnt_reg;
    logic        frame_done_reg;
    logic        err_multi_reg;
    logic        err_pattern_reg;
    logic        scan_timeout_reg;

    logic        changed;
    logic        any_low;
    logic [7:0]  sel;
    logic        single;
    logic        capture;
    logic        capture_digit;
    logic        capture_multi;
    logic        frame_hit;
    logic [3:0]  dec_val;
    logic        dec_legal;
    logic        dec_blank;

    // Input sampling: one register stage, then a copy of the previous sample
    // so stability can be judged on clean registered values. Idle-bus values
    // on reset keep the first post-reset compare from seeing a false change.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_s_reg   <= 8'hFF;
            cathode_s_reg <= 7'h7F;
            anode_p_reg   <= 8'hFF;
            cathode_p_reg <= 7'h7F;
        end else begin
            anode_s_reg   <= anode;
            cathode_s_reg <= cathode;
            anode_p_reg   <= anode_s_reg;
            cathode_p_reg <= cathode_s_reg;
        end
    end

    assign changed = (anode_s_reg != anode_p_reg) || (cathode_s_reg != cathode_p_reg);
    assign any_low = (anode_s_reg != 8'hFF);
    assign sel     = ~anode_s_reg;
    assign single  = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);

    // Scan FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: settle on a stable digit, capture once, then hold
    // until the bus moves again.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_low) begin
                    state_next = SETTLE;
                    cnt_next   = 8'd1;
                end
            end
            SETTLE: begin
                if (!any_low) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else if (changed) begin
                    cnt_next = 8'd1;
                end else if (cnt_reg >= SETTLE_TERM) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            HOLD: begin
                if (changed) begin
                    if (any_low) begin
                        state_next = SETTLE;
                        cnt_next   = 8'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Active-low segment decode of the sampled cathode pattern.
    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (cathode_s_reg)
            7'h01: dec_val = 4'h0;
            7'h4F: dec_val = 4'h1;
            7'h12: dec_val = 4'h2;
            7'h06: dec_val = 4'h3;
            7'h4C: dec_val = 4'h4;
            7'h24: dec_val = 4'h5;
            7'h20: dec_val = 4'h6;
            7'h0F: dec_val = 4'h7;
            7'h00: dec_val = 4'h8;
            7'h04: dec_val = 4'h9;
            7'h08: dec_val = 4'hA;
            7'h60: dec_val = 4'hB;
            7'h31: dec_val = 4'hC;
            7'h42: dec_val = 4'hD;
            7'h30: dec_val = 4'hE;
            7'h38: dec_val = 4'hF;
            7'h7F: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign capture_digit = capture && single;
    assign capture_multi = capture && !single;
    // The current capture's bit is merged before the full-frame compare.
    assign frame_hit     = capture_digit && ((seen_reg | sel) == 8'hFF);

    // Per-digit result registers; only the selected digit changes on a capture.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            logic [3:0] val_reg;
            logic       valid_reg;
            logic       blank_reg;

            // Update this digit's value and status on its own capture.
            always_ff @(posedge clk) begin
                if (reset) begin
                    val_reg   <= 4'h0;
                    valid_reg <= 1'b0;
                    blank_reg <= 1'b0;
                end else if (capture_digit && sel[gi]) begin
                    if (dec_legal) begin
                        val_reg   <= dec_val;
                        valid_reg <= 1'b1;
                        blank_reg <= 1'b0;
                    end else begin
                        valid_reg <= 1'b0;
                        blank_reg <= dec_blank;
                    end
                end
            end

            assign digits[4*gi +: 4] = val_reg;
            assign digit_valid[gi]   = valid_reg;
            assign digit_blank[gi]   = blank_reg;
        end
    endgenerate

    // Seen mask and frame pulse: a full set of captures pulses once and restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_reg       <= 8'd0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_hit;
            if (capture_digit) begin
                seen_reg <= frame_hit ? 8'd0 : (seen_reg | sel);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_multi_reg   <= 1'b0;
            err_pattern_reg <= 1'b0;
        end else begin
            if (capture_multi) begin
                err_multi_reg <= 1'b1;
            end
            if (capture_digit && !dec_legal && !dec_blank) begin
                err_pattern_reg <= 1'b1;
            end
        end
    end

    // Frame watchdog: a completed frame restarts the count and wins over a
    // simultaneous terminal count; otherwise it saturates and flags a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_reg      <= 20'd0;
            scan_timeout_reg <= 1'b0;
        end else if (frame_hit) begin
            tmo_cnt_reg <= 20'd0;
        end else begin
            if (tmo_cnt_reg != TMO_TERM) begin
                tmo_cnt_reg <= tmo_cnt_reg + 20'd1;
            end
            if ((tmo_cnt_reg + 20'd1 == TMO_TERM) || (tmo_cnt_reg == TMO_TERM)) begin
                scan_timeout_reg <= 1'b1;
            end
        end
    end

    assign frame_done   = frame_done_reg;
    assign err_multi    = err_multi_reg;
    assign err_pattern  = err_pattern_reg;
    assign scan_timeout = scan_timeout_reg;

endmodule
